// File: rtl/k16_execute_stage_pkg.sv
// Shared K16 definitions: datapath widths, ALU class/operation codes and flag positions.
package k16_execute_stage_pkg;

    localparam int unsigned K16_DATA_W    = 16;
    localparam int unsigned K16_REG_COUNT = 8;
    localparam int unsigned K16_REG_IDX_W = 3;
    localparam int unsigned K16_OPTYPE_W  = 3;
    localparam int unsigned K16_OP_W      = 3;

    // ALU operation classes
    localparam logic [K16_OPTYPE_W-1:0] OPTYPE_ALU   = 3'd0;
    localparam logic [K16_OPTYPE_W-1:0] OPTYPE_SHIFT = 3'd1;
    localparam logic [K16_OPTYPE_W-1:0] OPTYPE_LOAD  = 3'd2;

    // Operations within OPTYPE_ALU
    localparam logic [K16_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [K16_OP_W-1:0] OP_ADC = 3'd1;
    localparam logic [K16_OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [K16_OP_W-1:0] OP_SBC = 3'd3;
    localparam logic [K16_OP_W-1:0] OP_AND = 3'd4;
    localparam logic [K16_OP_W-1:0] OP_OR  = 3'd5;
    localparam logic [K16_OP_W-1:0] OP_XOR = 3'd6;
    localparam logic [K16_OP_W-1:0] OP_NOT = 3'd7;

    // Operations within OPTYPE_SHIFT and OPTYPE_LOAD
    localparam logic [K16_OP_W-1:0] OP_SHL  = 3'd0;
    localparam logic [K16_OP_W-1:0] OP_SHR  = 3'd1;
    localparam logic [K16_OP_W-1:0] OP_ASR  = 3'd2;
    localparam logic [K16_OP_W-1:0] OP_ROL  = 3'd3;
    localparam logic [K16_OP_W-1:0] OP_COPY = 3'd0;

    // Bit positions inside the {C,Z,N} flag-enable vector
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/k16_regfile.sv
// General register file: two async read ports, one debug read port, one sync write port.
module k16_regfile #(
    parameter  int unsigned REG_COUNT  = 8,
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned IDX_W      = $clog2(REG_COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr_a,
    input  logic [IDX_W-1:0]      i_raddr_b,
    input  logic [IDX_W-1:0]      i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_rdata_a_c,
    output logic [DATA_WIDTH-1:0] o_rdata_b_c,
    output logic [DATA_WIDTH-1:0] o_dbg_data_c
);

    logic [DATA_WIDTH-1:0] r_mem [REG_COUNT];

    // Reset wins over a same-cycle write so a dropped instruction never lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a_c  = r_mem[i_raddr_a];
    assign o_rdata_b_c  = r_mem[i_raddr_b];
    assign o_dbg_data_c = r_mem[i_dbg_addr];

endmodule

// File: rtl/k16_execute_stage.sv
// K16 execute/writeback stage: latches one instruction into E, drives the external ALU,
// and retires its result and flags on the following non-stalled edge.
module k16_execute_stage
    import k16_execute_stage_pkg::*;
#(
    parameter  int unsigned REG_COUNT  = K16_REG_COUNT,
    parameter  int unsigned DATA_WIDTH = K16_DATA_W,
    localparam int unsigned IDX_W      = $clog2(REG_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issueValid,
    output logic                    issueReady,
    input  logic                    stall,
    input  logic [IDX_W-1:0]        srcA,
    input  logic [IDX_W-1:0]        srcB,
    input  logic [IDX_W-1:0]        dest,
    input  logic                    useImm,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic [K16_OPTYPE_W-1:0] opType,
    input  logic [K16_OP_W-1:0]     opCode,
    input  logic                    writeResult,
    input  logic [2:0]              flagWe,
    output logic [DATA_WIDTH-1:0]   aluOperand1,
    output logic [DATA_WIDTH-1:0]   aluOperand2,
    output logic                    aluCarryIn,
    output logic [K16_OPTYPE_W-1:0] aluOpType,
    output logic [K16_OP_W-1:0]     aluOp,
    input  logic [DATA_WIDTH-1:0]   aluResult,
    input  logic                    aluCarry,
    input  logic                    aluZero,
    input  logic                    aluNegative,
    output logic                    flagC,
    output logic                    flagZ,
    output logic                    flagN,
    output logic                    retireValid,
    output logic [IDX_W-1:0]        retireReg,
    output logic [DATA_WIDTH-1:0]   retireData,
    input  logic [IDX_W-1:0]        dbgSel,
    output logic [DATA_WIDTH-1:0]   dbgData
);

    logic                    r_eValid;
    logic [DATA_WIDTH-1:0]   r_op1;
    logic [DATA_WIDTH-1:0]   r_op2;
    logic [K16_OPTYPE_W-1:0] r_opType;
    logic [K16_OP_W-1:0]     r_op;
    logic [IDX_W-1:0]        r_dest;
    logic                    r_writeResult;
    logic [2:0]              r_flagWe;
    logic                    r_flagC;
    logic                    r_flagZ;
    logic                    r_flagN;
    logic                    r_retireValid;
    logic [IDX_W-1:0]        r_retireReg;
    logic [DATA_WIDTH-1:0]   r_retireData;

    logic                  w_accept;
    logic                  w_retire;
    logic [DATA_WIDTH-1:0] w_rdA;
    logic [DATA_WIDTH-1:0] w_rdB;
    logic [DATA_WIDTH-1:0] w_op1Next;
    logic [DATA_WIDTH-1:0] w_op2Next;

    assign issueReady = !stall;
    assign w_accept   = issueValid && !stall;
    assign w_retire   = r_eValid && !stall;

    k16_regfile #(
        .REG_COUNT  (REG_COUNT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_we         (w_retire && r_writeResult),
        .i_waddr      (r_dest),
        .i_wdata      (aluResult),
        .i_raddr_a    (srcA),
        .i_raddr_b    (srcB),
        .i_dbg_addr   (dbgSel),
        .o_rdata_a_c  (w_rdA),
        .o_rdata_b_c  (w_rdB),
        .o_dbg_data_c (dbgData)
    );

    // Forward the in-flight result when E is about to write the register being read.
    always_comb begin
        w_op1Next = w_rdA;
        w_op2Next = w_rdB;
        if (r_eValid && r_writeResult && (r_dest == srcA)) begin
            w_op1Next = aluResult;
        end
        if (r_eValid && r_writeResult && (r_dest == srcB)) begin
            w_op2Next = aluResult;
        end
        if (useImm) begin
            w_op2Next = imm;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_eValid      <= 1'b0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_opType      <= '0;
            r_op          <= '0;
            r_dest        <= '0;
            r_writeResult <= 1'b0;
            r_flagWe      <= '0;
            r_flagC       <= 1'b0;
            r_flagZ       <= 1'b0;
            r_flagN       <= 1'b0;
            r_retireValid <= 1'b0;
            r_retireReg   <= '0;
            r_retireData  <= '0;
        end else begin
            r_retireValid <= w_retire;
            if (!stall) begin
                r_eValid <= w_accept;
            end
            if (w_accept) begin
                r_op1         <= w_op1Next;
                r_op2         <= w_op2Next;
                r_opType      <= opType;
                r_op          <= opCode;
                r_dest        <= dest;
                r_writeResult <= writeResult;
                r_flagWe      <= flagWe;
            end
            // Flags land on the same edge that loads the next E, so ADC chains need no bubble.
            if (w_retire) begin
                r_retireReg  <= r_dest;
                r_retireData <= aluResult;
                if (r_flagWe[FLAG_C]) r_flagC <= aluCarry;
                if (r_flagWe[FLAG_Z]) r_flagZ <= aluZero;
                if (r_flagWe[FLAG_N]) r_flagN <= aluNegative;
            end
        end
    end

    assign aluOperand1 = r_op1;
    assign aluOperand2 = r_op2;
    assign aluCarryIn  = r_flagC;
    assign aluOpType   = r_opType;
    assign aluOp       = r_op;
    assign flagC       = r_flagC;
    assign flagZ       = r_flagZ;
    assign flagN       = r_flagN;
    assign retireValid = r_retireValid;
    assign retireReg   = r_retireReg;
    assign retireData  = r_retireData;

endmodule

// File: tb/tb_k16_execute_stage.sv
// Bench for k16_execute_stage: a behavioural ALU stands in for the external one, and an
// in-order ISA-level model predicts retirements, flags, register contents and ALU drive.
`timescale 1ns/1ps
module tb_k16_execute_stage;
    import k16_execute_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        issueValid;
    logic        issueReady;
    logic        stall;
    logic [2:0]  srcA, srcB, dest;
    logic        useImm;
    logic [15:0] imm;
    logic [2:0]  opType, opCode;
    logic        writeResult;
    logic [2:0]  flagWe;
    logic [15:0] aluOperand1, aluOperand2;
    logic        aluCarryIn;
    logic [2:0]  aluOpType, aluOp;
    logic [15:0] aluResult;
    logic        aluCarry, aluZero, aluNegative;
    logic        flagC, flagZ, flagN;
    logic        retireValid;
    logic [2:0]  retireReg;
    logic [15:0] retireData;
    logic [2:0]  dbgSel;
    logic [15:0] dbgData;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    k16_execute_stage dut (
        .clock(clock), .reset(reset), .issueValid(issueValid), .issueReady(issueReady),
        .stall(stall), .srcA(srcA), .srcB(srcB), .dest(dest), .useImm(useImm), .imm(imm),
        .opType(opType), .opCode(opCode), .writeResult(writeResult), .flagWe(flagWe),
        .aluOperand1(aluOperand1), .aluOperand2(aluOperand2), .aluCarryIn(aluCarryIn),
        .aluOpType(aluOpType), .aluOp(aluOp), .aluResult(aluResult), .aluCarry(aluCarry),
        .aluZero(aluZero), .aluNegative(aluNegative), .flagC(flagC), .flagZ(flagZ),
        .flagN(flagN), .retireValid(retireValid), .retireReg(retireReg),
        .retireData(retireData), .dbgSel(dbgSel), .dbgData(dbgData)
    );

    // Behavioural K16 ALU: returns {carryOut, result}
    function automatic logic [16:0] alu_f(input logic [2:0] t, input logic [2:0] o,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [16:0] s;
        s = '0;
        case (t)
            OPTYPE_ALU: case (o)
                OP_ADD:  s = {1'b0, a} + {1'b0, b};
                OP_ADC:  s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                OP_SBC:  s = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
                OP_AND:  s = {1'b0, a & b};
                OP_OR:   s = {1'b0, a | b};
                OP_XOR:  s = {1'b0, a ^ b};
                default: s = {1'b0, ~a};
            endcase
            OPTYPE_SHIFT: case (o)
                OP_SHL:  s = {a, 1'b0};
                OP_SHR:  s = {a[0], 1'b0, a[15:1]};
                OP_ASR:  s = {a[0], a[15], a[15:1]};
                OP_ROL:  s = {a[15], a[14:0], a[15]};
                default: s = {1'b0, a};
            endcase
            OPTYPE_LOAD: s = (o == OP_COPY) ? {1'b0, b} : {1'b0, a};
            default: s = '0;
        endcase
        return s;
    endfunction

    always_comb begin
        {aluCarry, aluResult} = alu_f(aluOpType, aluOp, aluOperand1, aluOperand2, aluCarryIn);
        aluZero     = (aluResult == 16'd0);
        aluNegative = aluResult[15];
    end

    // ISA-level state (effects applied at accept) and committed state (applied at retire)
    logic [15:0] isa_reg [8];
    logic [15:0] cm_reg  [8];
    logic [2:0]  isa_f, cm_f;
    logic        pend_v;
    logic [15:0] pend_op1, pend_op2, pend_data;
    logic        pend_cin, pend_wr;
    logic [2:0]  pend_t, pend_o, pend_dest, pend_fnew;
    logic        exp_rv;
    logic [2:0]  exp_rr;
    logic [15:0] exp_rd;
    logic        was_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        logic [16:0] s;
        logic [2:0]  fl;
        was_reset = reset;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin isa_reg[i] = '0; cm_reg[i] = '0; end
            isa_f = '0; cm_f = '0; pend_v = 0; exp_rv = 0; exp_rr = '0; exp_rd = '0;
        end else if (stall) begin
            exp_rv = 0;
        end else begin
            exp_rv = pend_v;
            if (pend_v) begin
                if (pend_wr) cm_reg[pend_dest] = pend_data;
                cm_f   = pend_fnew;
                exp_rr = pend_dest;
                exp_rd = pend_data;
            end
            pend_v = issueValid;
            if (issueValid) begin
                pend_op1 = isa_reg[srcA];
                pend_op2 = useImm ? imm : isa_reg[srcB];
                pend_cin = isa_f[FLAG_C];
                pend_t = opType; pend_o = opCode; pend_dest = dest; pend_wr = writeResult;
                s  = alu_f(opType, opCode, pend_op1, pend_op2, pend_cin);
                fl = {s[16], s[15:0] == 16'd0, s[15]};
                pend_data = s[15:0];
                pend_fnew = (isa_f & ~flagWe) | (fl & flagWe);
                if (writeResult) isa_reg[dest] = pend_data;
                isa_f = pend_fnew;
            end
        end
    endtask

    task automatic compare();
        chk("retireValid", 32'(retireValid), 32'(exp_rv));
        if (exp_rv) begin
            chk("retireReg",  32'(retireReg),  32'(exp_rr));
            chk("retireData", 32'(retireData), 32'(exp_rd));
        end
        chk("flags CZN", 32'({flagC, flagZ, flagN}), 32'(cm_f));
        chk("dbgData", 32'(dbgData), 32'(cm_reg[dbgSel]));
        chk("issueReady", 32'(issueReady), 32'(!stall));
        if (was_reset) begin
            chk("rst aluOperand1", 32'(aluOperand1), 32'd0);
            chk("rst aluOperand2", 32'(aluOperand2), 32'd0);
            chk("rst aluOpType/Op", 32'({aluOpType, aluOp}), 32'd0);
        end else if (pend_v) begin
            chk("aluOperand1", 32'(aluOperand1), 32'(pend_op1));
            chk("aluOperand2", 32'(aluOperand2), 32'(pend_op2));
            chk("aluCarryIn",  32'(aluCarryIn),  32'(pend_cin));
            chk("aluOpType/Op", 32'({aluOpType, aluOp}), 32'({pend_t, pend_o}));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic issue(input logic [2:0] t, input logic [2:0] o, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] d, input logic ui,
                         input logic [15:0] im, input logic wr, input logic [2:0] fwe);
        issueValid = 1; opType = t; opCode = o; srcA = a; srcB = b; dest = d;
        useImm = ui; imm = im; writeResult = wr; flagWe = fwe;
        cycle();
        issueValid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; issueValid = 0; stall = 0; srcA = 0; srcB = 0; dest = 0; useImm = 0;
        imm = 0; opType = 0; opCode = 0; writeResult = 0; flagWe = 0; dbgSel = 0;
        pend_v = 0;
        cycle();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            dbgSel = 3'(i);
            cycle();
            chk("reset reg zero", 32'(dbgData), 32'd0);
        end

        // Immediate load into r1
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 1, 1, 16'h8235, 1, 3'b000);
        cycle();
        chk("load r1 valid", 32'(retireValid), 32'd1);
        chk("load r1 data", 32'(retireData), 32'h8235);

        // r1=000A, r2=000F, set C via FFFF+1, then ADC r3=r1+r2
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 1, 1, 16'h000A, 1, 3'b000);
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 2, 1, 16'h000F, 1, 3'b000);
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 6, 1, 16'hFFFF, 1, 3'b000);
        issue(OPTYPE_ALU, OP_ADD, 6, 0, 0, 1, 16'h0001, 0, 3'b100);
        issue(OPTYPE_ALU, OP_ADC, 1, 2, 3, 0, 16'h0000, 1, 3'b111);
        cycle();
        chk("adc r3 data", 32'(retireData), 32'h001A);
        chk("adc flags", 32'({flagC, flagZ, flagN}), 32'b000);

        // Back-to-back dependency through the bypass
        issue(OPTYPE_ALU, OP_ADD, 1, 1, 4, 0, 16'h0000, 1, 3'b000);
        issue(OPTYPE_ALU, OP_ADD, 4, 4, 5, 0, 16'h0000, 1, 3'b000);
        cycle();
        chk("bypass r5 reg", 32'(retireReg), 32'd5);
        chk("bypass r5 data", 32'(retireData), 32'h0028);

        // Carry chain: F000+1243 sets C, ADC 0+0 consumes it immediately
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 6, 1, 16'hF000, 1, 3'b000);
        issue(OPTYPE_ALU, OP_ADD, 6, 0, 6, 1, 16'h1243, 1, 3'b100);
        issue(OPTYPE_ALU, OP_ADC, 0, 0, 7, 0, 16'h0000, 1, 3'b100);
        cycle();
        chk("carry chain r7", 32'(retireData), 32'h0001);
        dbgSel = 6;
        cycle();
        chk("carry chain r6", 32'(dbgData), 32'h0243);

        // Stall holds E for three cycles, then retires
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 2, 1, 16'h1234, 1, 3'b000);
        stall = 1;
        dbgSel = 2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall issueReady", 32'(issueReady), 32'd0);
            chk("stall no retire", 32'(retireValid), 32'd0);
            chk("stall r2 held", 32'(dbgData), 32'h000F);
        end
        stall = 0;
        cycle();
        chk("stall release data", 32'(retireData), 32'h1234);

        // Flags to 001 via 0-1, then SHL with no flag update, then a no-write COPY
        issue(OPTYPE_ALU, OP_SUB, 0, 0, 0, 1, 16'h0001, 0, 3'b111);
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 4, 1, 16'h8234, 1, 3'b000);
        issue(OPTYPE_SHIFT, OP_SHL, 4, 0, 5, 0, 16'h0000, 1, 3'b000);
        cycle();
        chk("shl data", 32'(retireData), 32'h0468);
        chk("shl flags held", 32'({flagC, flagZ, flagN}), 32'b001);
        dbgSel = 5;
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 5, 1, 16'h0000, 0, 3'b111);
        cycle();
        chk("nowrite r5 held", 32'(dbgData), 32'h0468);
        chk("nowrite flags", 32'({flagC, flagZ, flagN}), 32'b010);

        // dest==srcA==srcB, back to back
        issue(OPTYPE_ALU, OP_ADD, 1, 1, 1, 0, 16'h0000, 1, 3'b000);
        issue(OPTYPE_ALU, OP_ADD, 1, 1, 1, 0, 16'h0000, 1, 3'b000);
        cycle();
        chk("self bypass r1", 32'(retireData), 32'h0028);

        // Reset mid-stream drops the in-flight instruction
        issue(OPTYPE_LOAD, OP_COPY, 0, 0, 3, 1, 16'hBEEF, 1, 3'b111);
        reset = 1;
        cycle();
        reset = 0;
        dbgSel = 3;
        cycle();
        chk("reset drop r3", 32'(dbgData), 32'h0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 99) < 20);
            issueValid  = ($urandom_range(0, 99) < 75);
            srcA        = 3'($urandom_range(0, 7));
            srcB        = 3'($urandom_range(0, 7));
            dest        = 3'($urandom_range(0, 7));
            useImm      = 1'($urandom_range(0, 1));
            imm         = 16'($urandom);
            opType      = 3'($urandom_range(0, 3));
            opCode      = 3'($urandom_range(0, 7));
            writeResult = ($urandom_range(0, 99) < 80);
            flagWe      = 3'($urandom_range(0, 7));
            dbgSel      = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
